// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and helpers for the seven-segment scan controller
package seg_scan_pkg;

  typedef logic [3:0] nibble_t;

  function automatic int slot_width(input int digits);
    return ($clog2(digits) < 1) ? 1 : $clog2(digits);
  endfunction

  // Maps a logical "digit lit" to the pin level for the chosen polarity.
  function automatic logic digit_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - load/display bundle between the scan controller and its host
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  import seg_scan_pkg::*;

  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank_en;
  nibble_t             nibble;
  logic                rbi;
  logic [DIGITS-1:0]   digit_en;
  logic                frame;
  logic                pending;

  modport master (
    output value, load, blank_en,
    input  nibble, rbi, digit_en, frame, pending
  );

  modport slave (
    input  value, load, blank_en,
    output nibble, rbi, digit_en, frame, pending
  );

endinterface

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - per-slot cycle counter with slot-start, terminal and lit-window flags
module seg_scan_prescaler #(
  parameter int PRESCALE = 1024,
  parameter int DEAD     = 8
) (
  input  logic clk,
  input  logic rst,
  output logic start_o,
  output logic tc_o,
  output logic lit_o
);
  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt_q, cnt_d;

  assign start_o = (cnt_q == '0);
  assign tc_o    = (cnt_q == CW'(PRESCALE - 1));
  assign lit_o   = (cnt_q < CW'(PRESCALE - DEAD));

  always_comb begin
    cnt_d = tc_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed seven-segment scan controller, MSD first, double-buffered value
// Counter/slot state leads the output registers by one cycle so every output is a flop.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int PRESCALE         = 1024,
  parameter int DEAD             = 8,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input logic        clk,
  input logic        rst,
  seg_scan_if.slave  bus
);
  localparam int              SW  = slot_width(DIGITS);
  localparam logic [SW-1:0]   MSD = SW'(DIGITS - 1);

  logic start, tc, lit;

  seg_scan_prescaler #(.PRESCALE(PRESCALE), .DEAD(DEAD)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .start_o (start),
    .tc_o    (tc),
    .lit_o   (lit)
  );

  logic [SW-1:0]       slot_q, slot_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic                pending_q, pending_d;
  logic                zrun_q, zrun_d;
  nibble_t             nibble_q, nibble_d;
  logic                rbi_q, rbi_d;
  logic                frame_q, frame_d;
  logic [DIGITS-1:0]   den_q, den_d;
  logic                frame_edge, zrun_cur;
  nibble_t             cur_nib;

  always_comb begin
    frame_edge = start && (slot_q == MSD);

    slot_d = slot_q;
    if (tc) slot_d = (slot_q == '0) ? MSD : slot_q - SW'(1);

    shadow_d  = bus.load ? bus.value : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (frame_edge) begin
      // A load landing on the boundary bypasses the shadow entirely.
      disp_d    = bus.load ? bus.value : (pending_q ? shadow_q : disp_q);
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    cur_nib  = disp_d[4*int'(slot_q) +: 4];
    zrun_cur = frame_edge ? bus.blank_en : zrun_q;

    zrun_d   = zrun_q;
    nibble_d = nibble_q;
    rbi_d    = rbi_q;
    if (start) begin
      zrun_d   = zrun_cur && (cur_nib == '0);
      nibble_d = cur_nib;
      rbi_d    = zrun_d && (slot_q != '0);
    end

    frame_d = frame_edge;
    for (int i = 0; i < DIGITS; i++) begin
      den_d[i] = digit_level(lit && (int'(slot_q) == i), DIGIT_ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= MSD;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      zrun_q    <= 1'b0;
      nibble_q  <= '0;
      rbi_q     <= 1'b0;
      frame_q   <= 1'b0;
      den_q     <= {DIGITS{DIGIT_ACTIVE_LOW}};
    end else begin
      slot_q    <= slot_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      zrun_q    <= zrun_d;
      nibble_q  <= nibble_d;
      rbi_q     <= rbi_d;
      frame_q   <= frame_d;
      den_q     <= den_d;
    end
  end

  assign bus.nibble   = nibble_q;
  assign bus.rbi      = rbi_q;
  assign bus.digit_en = den_q;
  assign bus.frame    = frame_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan against a frame-level reference model
module tb_seg_scan;
  import seg_scan_pkg::*;

  localparam int D  = 4;
  localparam int P  = 16;
  localparam int DD = 2;
  localparam int FR = D * P;
  localparam logic [10:0] RST_VEC = {4'h0, 1'b0, 4'hF, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  seg_scan_if #(.DIGITS(D)) bus();

  seg_scan #(.DIGITS(D), .PRESCALE(P), .DEAD(DD), .DIGIT_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: m_t counts output cycles since reset release; a frame's content is fixed at its start.
  int          m_t = -1;
  logic [15:0] m_disp = '0, m_shadow = '0;
  logic        m_pend = 1'b0, m_blank = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = -1; m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_blank = 1'b0;
    end else begin
      m_t = m_t + 1;
      if (m_t % FR == 0) begin
        if (bus.load)    m_disp = bus.value;
        else if (m_pend) m_disp = m_shadow;
        m_pend  = 1'b0;
        m_blank = bus.blank_en;
      end else if (bus.load) begin
        m_shadow = bus.value;
        m_pend   = 1'b1;
      end
    end
  end

  function automatic logic [10:0] exp_vec();
    int slot, cnt;
    logic [3:0] nib, den;
    logic r, fr;
    if (m_t < 0) return RST_VEC;
    cnt  = m_t % P;
    slot = D - 1 - (m_t / P) % D;
    nib  = m_disp[4*slot +: 4];
    r    = m_blank && (slot != 0) && ((m_disp >> (4*slot)) == 16'h0);
    den  = 4'hF;
    if (cnt < P - DD) den[slot] = 1'b0;
    fr   = (m_t % FR) == 0;
    return {nib, r, den, fr, m_pend};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bus.nibble, bus.rbi, bus.digit_en, bus.frame, bus.pending};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== RST_VEC) begin
        failures++;
        $display("FAIL reset_state got=%h exp=%h", obs_vec(), RST_VEC);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2*FR; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL scan t=%0d got=%h exp=%h", m_t, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_load();
    bit done = 0;
    bus.blank_en = 1'b0;
    for (int i = 0; i < 3*FR; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL load t=%0d got=%h exp=%h", m_t, obs_vec(), exp_vec());
      end
      bus.load  = !done && (m_t % FR == 19);
      bus.value = 16'h12AF;
      if (bus.load) done = 1;
    end
    bus.load = 1'b0;
  endtask

  task automatic test_blank();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    int stage = 0;
    bus.blank_en = 1'b1;
    for (int i = 0; i < 5*FR; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL blank t=%0d got=%h exp=%h", m_t, obs_vec(), exp_vec());
      end
      bus.load = 1'b0;
      if (stage < 2 && (m_t % FR == 40) && (i >= stage * 2 * FR)) begin
        bus.load  = 1'b1;
        bus.value = vals[stage];
        stage++;
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          offs [3] = '{4, 29, 63};
    logic [15:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
    int stage = 0;
    bus.blank_en = 1'b0;
    for (int i = 0; i < 3*FR; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h", m_t, obs_vec(), exp_vec());
      end
      bus.load = 1'b0;
      if (stage < 3 && (m_t % FR == offs[stage])) begin
        bus.load  = 1'b1;
        bus.value = vals[stage];
        stage++;
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10*FR; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random t=%0d got=%h exp=%h", m_t, obs_vec(), exp_vec());
      end
      bus.load  = ($urandom_range(0, 7) == 0);
      bus.value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.blank_en = 1'($urandom_range(0, 1));
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    bus.blank_en = 1'b0;
    while ((m_t % FR) != 39 && guard < 4*FR) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 4*FR) begin
      failures++;
      $display("FAIL reset_mid_sync got=%0d exp=39", m_t % FR);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs_vec(), RST_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== RST_VEC) begin
        failures++;
        $display("FAIL reset_mid_hold got=%h exp=%h", obs_vec(), RST_VEC);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < FR + 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_restart t=%0d got=%h exp=%h", m_t, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.blank_en = 1'b0;
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
